// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the decode/issue stage and the ALU.
//   - opcode constants for the instruction classes the stage understands
//   - ALU select codes (the ALU decodes exactly these values)
//   - immediate-format helpers that sign-extend the raw instruction fields
//   - issue_t: the packed payload carried from decode to the ALU
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] ALU_SEL_ADD  = 5'd0;
  localparam logic [4:0] ALU_SEL_SLL  = 5'd1;
  localparam logic [4:0] ALU_SEL_SLT  = 5'd2;
  localparam logic [4:0] ALU_SEL_SLTU = 5'd3;
  localparam logic [4:0] ALU_SEL_XOR  = 5'd4;
  localparam logic [4:0] ALU_SEL_SRL  = 5'd5;
  localparam logic [4:0] ALU_SEL_OR   = 5'd6;
  localparam logic [4:0] ALU_SEL_AND  = 5'd7;
  localparam logic [4:0] ALU_SEL_SUB  = 5'd8;
  localparam logic [4:0] ALU_SEL_B    = 5'd9;
  localparam logic [4:0] ALU_SEL_SRA  = 5'd13;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      sel;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } issue_t;

  localparam int ISSUE_W = $bits(issue_t);

  // I-type: inst[31:20]
  function automatic logic [XLEN-1:0] imm_i(input logic [11:0] f);
    return {{20{f[11]}}, f};
  endfunction

  // S-type: hi = inst[31:25], lo = inst[11:7]
  function automatic logic [XLEN-1:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, hi, lo};
  endfunction

  // B-type: same fields as S-type, scrambled, bit 0 always zero
  function automatic logic [XLEN-1:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

  // U-type: inst[31:12] in the upper bits
  function automatic logic [XLEN-1:0] imm_u(input logic [19:0] f);
    return {f, 12'b0};
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register pair.
//   clk, rst      : clock, synchronous active-high reset (clears data too)
//   flush         : clears both valid bits; an input accepted this cycle is lost
//   in_valid/in_ready/in_data    : upstream handshake; in_ready = skid empty
//   out_valid/out_ready/out_data : downstream handshake driven from main register
// in_ready is taken from registered state only, so out_ready never reaches it
// combinationally; the skid entry absorbs the one extra beat this costs.
module skid_buffer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          main_valid_reg, main_valid_next;
  logic          skid_valid_reg, skid_valid_next;
  logic [DW-1:0] main_data_reg, main_data_next;
  logic [DW-1:0] skid_data_reg, skid_data_next;
  logic          accept, drain;

  assign in_ready  = ~skid_valid_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid_reg & out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (!main_valid_reg || drain) begin
      // Main slot frees up: the older skid entry has priority. A held skid
      // entry implies in_ready=0, so no new input competes with it.
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_valid_next = 1'b1;
        main_data_next  = in_data;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      main_data_reg  <= main_data_next;
      skid_data_reg  <= skid_data_next;
    end
  end

endmodule

// File: rtl/alu_issue_decode.sv
// Decode/issue stage in front of the ALU. Decodes one RV32I instruction per
// cycle into ALU operands, select code and writeback controls, and registers
// the result behind a 2-entry valid/ready skid buffer.
//   clk, rst, flush                  : clock, sync reset, pipeline flush
//   in_valid, in_ready               : upstream handshake
//   inst, pc, rs1_data, rs2_data     : instruction and its operands
//   out_valid, out_ready             : downstream handshake
//   op1, op2, sel, rd, rd_we, illegal: decoded entry presented to the ALU
module alu_issue_decode #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [4:0]       sel,
  output logic [4:0]       rd,
  output logic             rd_we,
  output logic             illegal
);
  import riscv_pkg::*;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_field;
  logic       ill, we;
  issue_t     dec, held;
  logic [ISSUE_W-1:0] held_bits;

  assign opcode   = inst[6:0];
  assign rd_field = inst[11:7];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];

  always_comb begin
    dec     = '0;
    dec.rd  = rd_field;
    ill     = 1'b0;
    we      = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op1 = rs1_data;
        dec.op2 = rs2_data;
        dec.sel = {1'b0, funct7[5], funct3};
        we      = 1'b1;
        if (!(funct7 == FUNCT7_ZERO ||
              (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))))
          ill = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_i(inst[31:20]);
        dec.sel = {2'b00, funct3};
        we      = 1'b1;
        // Shifts carry only the shamt; funct7 lives in the upper imm bits.
        if (funct3 == 3'b001) begin
          dec.op2 = {27'b0, inst[24:20]};
          dec.sel = ALU_SEL_SLL;
          if (funct7 != FUNCT7_ZERO) ill = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.op2 = {27'b0, inst[24:20]};
          if (funct7 == FUNCT7_ALT)       dec.sel = ALU_SEL_SRA;
          else if (funct7 == FUNCT7_ZERO) dec.sel = ALU_SEL_SRL;
          else                            ill     = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.op2 = imm_u(inst[31:12]);
        dec.sel = ALU_SEL_B;
        we      = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1 = pc;
        dec.op2 = imm_u(inst[31:12]);
        we      = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link address; the target is handled elsewhere.
        dec.op1 = pc;
        dec.op2 = 32'd4;
        we      = 1'b1;
      end
      OPC_LOAD: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_i(inst[31:20]);
        we      = 1'b1;
      end
      OPC_STORE: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_s(inst[31:25], inst[11:7]);
      end
      OPC_BRANCH: begin
        dec.op1 = pc;
        dec.op2 = imm_b(inst[31:25], inst[11:7]);
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.op1 = '0;
      dec.op2 = '0;
      dec.sel = ALU_SEL_ADD;
      we      = 1'b0;
    end
    dec.rd_we   = we & (rd_field != 5'd0);
    dec.illegal = ill;
  end

  skid_buffer #(.DW(ISSUE_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held_bits)
  );

  assign held    = held_bits;
  assign op1     = held.op1;
  assign op2     = held.op2;
  assign sel     = held.sel;
  assign rd      = held.rd;
  assign rd_we   = held.rd_we;
  assign illegal = held.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Bench for alu_issue_decode: directed literal checks plus randomized traffic
// compared every cycle against a depth-2 FIFO model of decoded entries.
module tb_alu_issue_decode;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] inst = 0, pc = 0, rs1_data = 0, rs2_data = 0;
  logic        in_ready, out_valid, rd_we, illegal;
  logic [31:0] op1, op2;
  logic [4:0]  sel, rd;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_issue_decode #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .sel(sel), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  // Reference decode straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [6:0] opc = i[6:0];
    logic [2:0] f3  = i[14:12];
    logic [6:0] f7  = i[31:25];
    logic [31:0] iimm = {{20{i[31]}}, i[31:20]};
    logic [31:0] simm = {{20{i[31]}}, i[31:25], i[11:7]};
    logic [31:0] bimm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [31:0] uimm = i & 32'hFFFFF000;
    e.op1 = 0; e.op2 = 0; e.sel = 0; e.rd = i[11:7]; e.we = 0; e.ill = 0;
    case (opc)
      7'h33: begin
        if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
          e.op1 = a; e.op2 = b; e.sel = 5'(f3 + ((f7 == 7'h20) ? 8 : 0)); e.we = 1;
        end else e.ill = 1;
      end
      7'h13: begin
        e.op1 = a; e.we = 1;
        if (f3 == 1) begin
          if (f7 == 0) begin e.sel = 1; e.op2 = 32'(i[24:20]); end else e.ill = 1;
        end else if (f3 == 5) begin
          e.op2 = 32'(i[24:20]);
          if (f7 == 0) e.sel = 5; else if (f7 == 7'h20) e.sel = 13; else e.ill = 1;
        end else begin
          e.sel = 5'(f3); e.op2 = iimm;
        end
      end
      7'h37: begin e.sel = 9; e.op2 = uimm; e.we = 1; end
      7'h17: begin e.op1 = p; e.op2 = uimm; e.we = 1; end
      7'h6F, 7'h67: begin e.op1 = p; e.op2 = 4; e.we = 1; end
      7'h03: begin e.op1 = a; e.op2 = iimm; e.we = 1; end
      7'h23: begin e.op1 = a; e.op2 = simm; end
      7'h63: begin e.op1 = p; e.op2 = bimm; end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.op1 = 0; e.op2 = 0; e.sel = 0; e.we = 0; end
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Advance one clock edge, updating the FIFO model with what the DUT saw.
  task automatic cycle();
    bit acc, drn;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if (rst || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(model(inst, pc, rs1_data, rs2_data));
    end
    #1;
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("op1", op1, q[0].op1);
        chk("op2", op2, q[0].op2);
        chk("sel", 32'(sel), 32'(q[0].sel));
        chk("rd", 32'(rd), 32'(q[0].rd));
        chk("rd_we", 32'(rd_we), 32'(q[0].we));
        chk("illegal", 32'(illegal), 32'(q[0].ill));
      end
      $display("cyc t=%0t iv=%0b ir=%0b ov=%0b or=%0b sel=%0d rd=%0d q=%0d",
               $time, in_valid, in_ready, out_valid, out_ready, sel, rd, q.size());
    end
  end

  // Issue one instruction with out_ready=1 and check it one cycle later.
  task automatic issue1(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
    in_valid = 1; inst = i; pc = p; rs1_data = a; rs2_data = b; out_ready = 1;
    cycle();
    in_valid = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                              7'h67, 7'h03, 7'h23, 7'h63, 7'h00};
    logic [31:0] r = $urandom;
    logic [6:0] o = opcs[$urandom_range(0, 9)];
    int k = $urandom_range(0, 2);
    if (o == 7'h00) o = 7'($urandom);
    if (k == 0) r[31:25] = 7'h00;
    else if (k == 1) r[31:25] = 7'h20;
    r[6:0] = o;
    return r;
  endfunction

  initial begin
    rst = 1;
    cycle(); chk_en = 1; cycle();
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst op1", op1, 0);
    chk("rst op2", op2, 0);
    chk("rst sel", 32'(sel), 0);
    chk("rst rd", 32'(rd), 0);
    chk("rst rd_we", 32'(rd_we), 0);
    chk("rst illegal", 32'(illegal), 0);
    rst = 0;
    cycle();

    // Hand-computed decode literals.
    issue1(32'h002081B3, 0, 5, 7);
    chk("add op1", op1, 5); chk("add op2", op2, 7); chk("add sel", 32'(sel), 0);
    chk("add rd", 32'(rd), 3); chk("add we", 32'(rd_we), 1); chk("add ov", 32'(out_valid), 1);
    cycle();
    issue1(32'h40435293, 0, 32'h80000000, 0);
    chk("srai sel", 32'(sel), 13); chk("srai op2", op2, 4); chk("srai op1", op1, 32'h80000000);
    cycle();
    issue1(32'h40208033, 0, 9, 4);
    chk("sub sel", 32'(sel), 8); chk("sub we", 32'(rd_we), 0);
    cycle();
    issue1(32'h123450B7, 0, 1, 1);
    chk("lui sel", 32'(sel), 9); chk("lui op2", op2, 32'h12345000); chk("lui op1", op1, 0);
    cycle();
    issue1(32'h00001097, 32'h100, 3, 3);
    chk("auipc op1", op1, 32'h100); chk("auipc op2", op2, 32'h1000); chk("auipc sel", 32'(sel), 0);
    cycle();
    issue1(32'h0000007F, 32'h40, 3, 3);
    chk("ill7f illegal", 32'(illegal), 1); chk("ill7f we", 32'(rd_we), 0); chk("ill7f sel", 32'(sel), 0);
    cycle();
    issue1(32'h40209093, 0, 3, 3);
    chk("slli-alt illegal", 32'(illegal), 1); chk("slli-alt we", 32'(rd_we), 0);
    chk("slli-alt op2", op2, 0);
    cycle();

    // Backpressure: three addi with rd=1,2,3 against a stalled output.
    out_ready = 0; in_valid = 1; rs1_data = 0;
    inst = {12'd1, 5'd0, 3'b000, 5'd1, 7'h13}; cycle();
    inst = {12'd2, 5'd0, 3'b000, 5'd2, 7'h13}; cycle();
    inst = {12'd3, 5'd0, 3'b000, 5'd3, 7'h13};
    @(negedge clk);
    chk("bp in_ready", 32'(in_ready), 0); chk("bp rd first", 32'(rd), 1);
    cycle(); cycle();
    @(negedge clk);
    chk("bp hold rd", 32'(rd), 1); chk("bp hold op2", op2, 1);
    out_ready = 1;
    cycle();
    @(negedge clk);
    chk("bp rel rd2", 32'(rd), 2); chk("bp rel ov2", 32'(out_valid), 1);
    cycle();
    in_valid = 0;
    @(negedge clk);
    chk("bp rel rd3", 32'(rd), 3); chk("bp rel ov3", 32'(out_valid), 1);
    cycle();
    @(negedge clk);
    chk("bp empty", 32'(out_valid), 0);

    // Flush with both entries full, plus an input in the flush cycle.
    out_ready = 0; in_valid = 1;
    inst = 32'h002081B3; cycle(); cycle();
    flush = 1; cycle();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush ov", 32'(out_valid), 0); chk("flush ir", 32'(in_ready), 1);
    out_ready = 1; cycle(); cycle();
    @(negedge clk);
    chk("flush stale", 32'(out_valid), 0);

    // Reset mid-stream.
    out_ready = 0; in_valid = 1; cycle(); cycle();
    rst = 1; cycle();
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst2 ov", 32'(out_valid), 0); chk("rst2 ir", 32'(in_ready), 1);
    chk("rst2 op1", op1, 0);
    out_ready = 1; cycle();
    @(negedge clk);
    chk("rst2 stale", 32'(out_valid), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 255) == 0);
      inst      = gen_inst();
      pc        = $urandom & 32'hFFFFFFFC;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      cycle();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    cycle(); cycle();
    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_decode.md
# alu_issue_decode

Registered decode/issue stage that drives the ALU's `op1`/`op2`/`sel` inputs. It accepts one RV32I instruction per cycle with its PC and register-file read data, and produces the ALU operands, the 5-bit ALU select code and writeback controls. Results are presented one cycle later behind a valid/ready handshake with a 2-entry skid buffer. It sits between register read and the ALU in the core pipeline.

## Interface
- `WIDTH`, 32: datapath width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous; drops every held entry.
- `in_valid`  in  1  instruction is presented.
- `in_ready`  out  1  stage can accept; equals `~skid_full`.
- `inst`  in  32  instruction word.
- `pc`  in  32  instruction address.
- `rs1_data`, `rs2_data`  in  32 each  register-file read data.
- `out_valid`  out  1  decoded entry is presented.
- `out_ready`  in  1  ALU/execute stage accepts.
- `op1`, `op2`  out  32 each  ALU operands.
- `sel`  out  5  ALU select: ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7, SUB 8, B (pass op2) 9, SRA 13.
- `rd`  out  5  destination register.
- `rd_we`  out  1  writeback enable; forced to 0 when `rd`==0.
- `illegal`  out  1  unsupported encoding.

## Operation
- OP (0110011): `sel`={0,funct7[5],funct3}. `op1`=rs1, `op2`=rs2. Legal funct7 values are 0000000, and 0100000 only with funct3 000 or 101.
- OP-IMM (0010011): `op2`=sign-extended I-imm, `op1`=rs1.
  - funct3 001: SLL; requires funct7=0.
  - funct3 101: SRA if funct7=0100000, SRL if funct7=0; any other funct7 is illegal.
  - Otherwise `sel`={00,funct3}. SUB is never generated.
- LUI: `sel`=B, `op1`=0, `op2`={inst[31:12],12'b0}.
- AUIPC: `sel`=ADD, `op1`=pc, `op2`=U-imm.
- JAL, JALR: `sel`=ADD, `op1`=pc, `op2`=4 (link value).
- LOAD: ADD, rs1 + I-imm, `rd_we`=1.
- STORE: ADD, rs1 + S-imm, `rd_we`=0.
- BRANCH: ADD, pc + B-imm, `rd_we`=0.
- Any other opcode, or any illegal funct field: `illegal`=1, `sel`=ADD, `op1`=`op2`=0, `rd_we`=0. The entry still flows through the handshake.
- Handshake:
  - Input is accepted when `in_valid & in_ready`.
  - Output transfers when `out_valid & out_ready`.
  - The skid entry captures an accepted input when the main register is valid and not draining.
  - When the main register drains, the skid entry (if any) moves into it.

## Timing
- Latency: an accepted instruction appears at the output on the next cycle if the output was empty or draining.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- `in_ready` depends only on registered state; there is no combinational path from `out_ready`.
- Reset values: `out_valid`=0, `in_ready`=1, `op1`=`op2`=0, `sel`=0, `rd`=0, `rd_we`=0, `illegal`=0. Reset mid-stream discards both entries.
- `flush` is treated the same as reset for valid bits: both entries are cleared. An input accepted in the flush cycle is dropped, and `out_valid`=0 on the next cycle. `rst` dominates `flush`.
- Output stability: while `out_valid & ~out_ready`, all outputs hold constant.
- Full: when the skid entry is occupied, `in_ready`=0. It returns to 1 on the cycle after the main register drains.
- Simultaneous accept and drain with an empty skid: the new entry goes directly to the main register and the skid stays empty.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH);
  - ALU select constants (`ALU_SEL_ADD` … `ALU_SEL_SRA`, `ALU_SEL_B`), shared with the ALU;
  - immediate-format helpers.
- Decode is combinational inside this module.
- Sub-module `skid_buffer` (parameter `DW`): 2-entry valid/ready register pair with a flush input, carrying the packed {op1, op2, sel, rd, rd_we, illegal} payload.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, `out_ready`=1 → next cycle `op1`=5, `op2`=7, `sel`=0, `rd`=3, `rd_we`=1.
- `srai x5,x6,4` (0x40435293), rs1=0x80000000 → `sel`=13, `op2`=4. `sub` (0x40208033) → `sel`=8, `rd_we`=0 (rd=x0).
- `lui x1,0x12345` (0x123450B7) → `sel`=9, `op2`=0x12345000. `auipc` with pc=0x100 and imm 1 → `op1`=0x100, `op2`=0x1000.
- Backpressure: hold `out_ready`=0 and issue 3 instructions → the first two are accepted, `in_ready`=0 on the third, and outputs stay stable. Release → the three emerge in order on consecutive cycles with no loss or duplication.
- Illegal: opcode 0x7F, and `slli` with funct7=0100000 → `illegal`=1, `rd_we`=0, `sel`=0.
- `flush` with both entries full, and `rst` asserted mid-stream → `out_valid`=0 next cycle, `in_ready`=1, and no stale entry reappears.
